// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice with a registered carry,
// operands consumed LSB-first, result presented after WIDTH bit-steps.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] op_a_reg, op_b_reg;
  logic             carry_reg;
  logic [WIDTH-2:0] res_sr_reg;
  logic [WIDTH-2:0] res_shift;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg, overflow_reg;

  logic s_bit, carry_maj, last_bit, accept;

  assign s_bit     = op_a_reg[0] ^ op_b_reg[0] ^ carry_reg;
  assign carry_maj = (op_a_reg[0] & op_b_reg[0]) | (op_a_reg[0] & carry_reg) |
                     (op_b_reg[0] & carry_reg);
  assign last_bit  = (cnt_reg == CW'(WIDTH - 1));
  assign accept    = start && (state_reg != RUN);

  // Result bits enter at the top and walk down, so after WIDTH-1 steps bit 0
  // sits at the LSB and the final slice output supplies the MSB directly.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 2; gi++) begin : g_res_shift
      assign res_shift[gi] = res_sr_reg[gi+1];
    end
  endgenerate
  assign res_shift[WIDTH-2] = s_bit;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      carry_reg    <= 1'b0;
      res_sr_reg   <= '0;
      cnt_reg      <= '0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + ~cin, i.e. a - b - cin.
      op_a_reg  <= a;
      op_b_reg  <= sub ? ~b : b;
      carry_reg <= sub ^ cin;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      op_a_reg   <= {1'b0, op_a_reg[WIDTH-1:1]};
      op_b_reg   <= {1'b0, op_b_reg[WIDTH-1:1]};
      carry_reg  <= carry_maj;
      res_sr_reg <= res_shift;
      cnt_reg    <= cnt_reg + CW'(1);
      if (last_bit) begin
        // carry_reg here is the carry into the MSB slice.
        sum_reg      <= {s_bit, res_sr_reg};
        cout_reg     <= carry_maj;
        overflow_reg <= carry_reg ^ carry_maj;
      end
    end
  end

  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = overflow_reg;

endmodule
